// File: rtl/dds_phase_acc.sv
// dds_phase_acc: DDS phase accumulator with glitch-free tuning-word update.
// Ports: CLK/RESET_N clock+async reset; ENABLE run/hold; SYNC phase clear;
//   FREQ_WORD/FREQ_VALID/FREQ_READY tuning-word handshake;
//   PHASE full phase, PHASE_TOP top OUT_W bits, WRAP carry pulse,
//   HALF msb 0->1 pulse.
module dds_phase_acc #(
  parameter int ACC_W          = 32,
  parameter int OUT_W          = 8,
  parameter bit UPDATE_AT_WRAP = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ENABLE,
  input  logic             SYNC,
  input  logic [ACC_W-1:0] FREQ_WORD,
  input  logic             FREQ_VALID,
  output logic             FREQ_READY,
  output logic [ACC_W-1:0] PHASE,
  output logic [OUT_W-1:0] PHASE_TOP,
  output logic             WRAP,
  output logic             HALF
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_inc;
  logic [ACC_W-1:0] r_shadow;
  logic             r_pend;
  logic             r_ready;
  logic             r_wrap;
  logic             r_half;

  state_t           w_state;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic             w_xfer;
  logic             w_apply;

  // State is a pure function of ENABLE and pend; no extra storage.
  always_comb begin
    w_state = ST_STOP;
    if (ENABLE) begin
      w_state = r_pend ? ST_PEND : ST_RUN;
    end
  end

  assign w_sum   = {1'b0, r_acc} + {1'b0, r_inc};
  assign w_carry = w_sum[ACC_W];

  // READY is !pend, so a transfer and an apply never coincide.
  assign w_xfer  = FREQ_VALID & r_ready;

  assign w_apply = r_pend & (SYNC
                           | (w_state == ST_STOP)
                           | !UPDATE_AT_WRAP
                           | w_carry);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_acc    <= '0;
      r_inc    <= '0;
      r_shadow <= '0;
      r_pend   <= 1'b0;
      r_ready  <= 1'b1;
      r_wrap   <= 1'b0;
      r_half   <= 1'b0;
    end else begin
      if (SYNC) begin
        r_acc  <= '0;
        r_wrap <= 1'b0;
        r_half <= 1'b0;
      end else if (w_state != ST_STOP) begin
        r_acc  <= w_sum[ACC_W-1:0];
        r_wrap <= w_carry;
        r_half <= !r_acc[ACC_W-1]
                & w_sum[ACC_W-1]
                & !w_carry;
      end else begin
        r_wrap <= 1'b0;
        r_half <= 1'b0;
      end

      // The add above still used the old inc on an apply edge.
      if (w_xfer) begin
        r_shadow <= FREQ_WORD;
        r_pend   <= 1'b1;
        r_ready  <= 1'b0;
      end else if (w_apply) begin
        r_inc    <= r_shadow;
        r_pend   <= 1'b0;
        r_ready  <= 1'b1;
      end
    end
  end

  assign FREQ_READY = r_ready;
  assign PHASE      = r_acc;
  assign PHASE_TOP  = r_acc[ACC_W-1 -: OUT_W];
  assign WRAP       = r_wrap;
  assign HALF       = r_half;

endmodule

// File: tb/tb_dds_phase_acc.sv
// tb_dds_phase_acc: directed bench for dds_phase_acc,
// one instance per UPDATE_AT_WRAP setting.
module tb_dds_phase_acc;

  logic        clk;
  logic        rst_n;

  logic        en0, sy0, v0;
  logic [31:0] w0;
  logic        rdy0, wr0, hf0;
  logic [31:0] ph0;
  logic [7:0]  top0;

  logic        en1, sy1, v1;
  logic [31:0] w1;
  logic        rdy1, wr1, hf1;
  logic [31:0] ph1;
  logic [7:0]  top1;

  int n_run;
  int n_fail;

  dds_phase_acc #(
    .ACC_W(32), .OUT_W(8), .UPDATE_AT_WRAP(1'b0)
  ) u0 (
    .CLK(clk), .RESET_N(rst_n),
    .ENABLE(en0), .SYNC(sy0),
    .FREQ_WORD(w0), .FREQ_VALID(v0),
    .FREQ_READY(rdy0), .PHASE(ph0),
    .PHASE_TOP(top0), .WRAP(wr0), .HALF(hf0)
  );

  dds_phase_acc #(
    .ACC_W(32), .OUT_W(8), .UPDATE_AT_WRAP(1'b1)
  ) u1 (
    .CLK(clk), .RESET_N(rst_n),
    .ENABLE(en1), .SYNC(sy1),
    .FREQ_WORD(w1), .FREQ_VALID(v1),
    .FREQ_READY(rdy1), .PHASE(ph1),
    .PHASE_TOP(top1), .WRAP(wr1), .HALF(hf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b1;
    en0 = 0; sy0 = 0; v0 = 0; w0 = '0;
    en1 = 0; sy1 = 0; v1 = 0; w1 = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_phase", ph0, 32'h0);
    chk("rst_top",   {24'h0, top0}, 32'h0);
    chk("rst_ready", {31'h0, rdy0}, 32'h1);
    chk("rst_wrap",  {31'h0, wr0}, 32'h0);
    chk("rst_half",  {31'h0, hf0}, 32'h0);
    #5 rst_n = 1'b1;

    // Basic handshake, UPDATE_AT_WRAP=0
    step();
    en0 = 1; v0 = 1; w0 = 32'h4000_0000;
    step();
    v0 = 0;
    chk("hs_ready_lo", {31'h0, rdy0}, 32'h0);
    step();
    chk("hs_ready_hi", {31'h0, rdy0}, 32'h1);
    chk("hs_top0",     {24'h0, top0}, 32'h00);
    step();
    chk("s1_top",  {24'h0, top0}, 32'h40);
    chk("s1_half", {31'h0, hf0}, 32'h0);
    step();
    chk("s2_top",  {24'h0, top0}, 32'h80);
    chk("s2_half", {31'h0, hf0}, 32'h1);
    chk("s2_wrap", {31'h0, wr0}, 32'h0);
    step();
    chk("s3_top",  {24'h0, top0}, 32'hC0);
    chk("s3_half", {31'h0, hf0}, 32'h0);
    step();
    chk("s4_top",  {24'h0, top0}, 32'h00);
    chk("s4_wrap", {31'h0, wr0}, 32'h1);
    chk("s4_half", {31'h0, hf0}, 32'h0);
    step();
    chk("s5_wrap", {31'h0, wr0}, 32'h0);

    // SYNC at 0xC0, where the next add would carry
    step();
    step();
    chk("pre_sync", {24'h0, top0}, 32'hC0);
    sy0 = 1;
    step();
    sy0 = 0;
    chk("sync_phase", ph0, 32'h0);
    chk("sync_wrap",  {31'h0, wr0}, 32'h0);
    step();
    chk("post_sync", {24'h0, top0}, 32'h40);

    // SYNC + handshake, then STOP applies the word
    sy0 = 1; v0 = 1; w0 = 32'hFFFF_FFFF;
    step();
    sy0 = 0; v0 = 0; en0 = 0;
    chk("sh_phase", ph0, 32'h0);
    chk("sh_ready", {31'h0, rdy0}, 32'h0);
    step();
    chk("stop_apply_rdy", {31'h0, rdy0}, 32'h1);
    chk("stop_apply_ph",  ph0, 32'h0);
    en0 = 1;
    step();
    chk("ff1_phase", ph0, 32'hFFFF_FFFF);
    chk("ff1_half",  {31'h0, hf0}, 32'h1);
    chk("ff1_wrap",  {31'h0, wr0}, 32'h0);
    step();
    chk("ff2_phase", ph0, 32'hFFFF_FFFE);
    chk("ff2_wrap",  {31'h0, wr0}, 32'h1);
    chk("ff2_half",  {31'h0, hf0}, 32'h0);
    step();
    chk("ff3_phase", ph0, 32'hFFFF_FFFD);
    chk("ff3_wrap",  {31'h0, wr0}, 32'h1);

    // ENABLE low with a word accepted
    en0 = 0; v0 = 1; w0 = 32'h1000_0000;
    step();
    v0 = 0;
    chk("stop_phase", ph0, 32'hFFFF_FFFD);
    chk("stop_wrap",  {31'h0, wr0}, 32'h0);
    chk("stop_rdy",   {31'h0, rdy0}, 32'h0);
    step();
    chk("stop2_phase", ph0, 32'hFFFF_FFFD);
    chk("stop2_rdy",   {31'h0, rdy0}, 32'h1);
    en0 = 1;
    step();
    chk("new_inc_ph",  ph0, 32'h0FFF_FFFD);
    chk("new_inc_wr",  {31'h0, wr0}, 32'h1);

    // Async reset mid-run with a word pending
    v0 = 1; w0 = 32'h0800_0000;
    step();
    v0 = 0;
    chk("pre_rst_rdy", {31'h0, rdy0}, 32'h0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_phase", ph0, 32'h0);
    chk("arst_rdy",   {31'h0, rdy0}, 32'h1);
    chk("arst_wrap",  {31'h0, wr0}, 32'h0);
    #3 rst_n = 1'b1;
    step();
    step();
    step();
    chk("post_rst_ph",  ph0, 32'h0);
    chk("post_rst_rdy", {31'h0, rdy0}, 32'h1);
    en0 = 0;

    // UPDATE_AT_WRAP=1: load while stopped, then run
    v1 = 1; w1 = 32'h4000_0000;
    step();
    v1 = 0;
    step();
    chk("u1_load_rdy", {31'h0, rdy1}, 32'h1);
    en1 = 1;
    step();
    chk("u1_s1", {24'h0, top1}, 32'h40);
    v1 = 1; w1 = 32'h2000_0000;
    step();
    v1 = 0;
    chk("u1_s2",     {24'h0, top1}, 32'h80);
    chk("u1_s2_rdy", {31'h0, rdy1}, 32'h0);
    step();
    chk("u1_s3",     {24'h0, top1}, 32'hC0);
    chk("u1_s3_rdy", {31'h0, rdy1}, 32'h0);
    step();
    chk("u1_s4",     {24'h0, top1}, 32'h00);
    chk("u1_s4_wr",  {31'h0, wr1}, 32'h1);
    chk("u1_s4_rdy", {31'h0, rdy1}, 32'h1);
    step();
    chk("u1_s5", {24'h0, top1}, 32'h20);
    step();
    chk("u1_s6", {24'h0, top1}, 32'h40);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
